// File: rtl/spi_slave.sv
// SPI mode-0 slave with 2-flop input synchronizers and a two-state (IDLE/SHIFT) FSM.
// Optional overrun flag output rx_overrun is enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic                  rx_overrun,
`endif
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            sclk_sync_q;
    logic [2:0]            cs_sync_q;
    logic [1:0]            mosi_sync_q;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q, busy_d;
    logic                  word_done_s;
    logic                  sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;

    // Bit [1] is the synchronized value, bit [2] its one-cycle-delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
        end
    end

    assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];

    // FSM state, shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_sr_q    <= {DATA_WIDTH{1'b0}};
            rx_sr_q    <= {DATA_WIDTH{1'b0}};
            cnt_q      <= {CW{1'b0}};
            miso_q     <= 1'b0;
            rx_data_q  <= {DATA_WIDTH{1'b0}};
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        word_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d = ST_SHIFT;
                    tx_sr_d = tx_data;
                    cnt_d   = {CW{1'b0}};
                    miso_d  = tx_data[DATA_WIDTH-1];
                end else begin
                    cnt_d  = {CW{1'b0}};
                    miso_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                    miso_d  = 1'b0;
                end else if (sclk_rise_s) begin
                    rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
                    if (cnt_q == CNT_LAST) begin
                        word_done_s = 1'b1;
                        rx_data_d   = {rx_sr_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
                        cnt_d       = {CW{1'b0}};
                        tx_sr_d     = tx_data;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (sclk_fall_s) begin
                    // A zero count here follows a word boundary: present the reloaded MSB unshifted
                    if (cnt_q == {CW{1'b0}}) begin
                        miso_d = tx_sr_q[DATA_WIDTH-1];
                    end else begin
                        tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                        miso_d  = tx_sr_q[DATA_WIDTH-2];
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // Completion wins over a simultaneous acknowledge
    always_comb begin
        if (word_done_s) begin
            rx_valid_d = 1'b1;
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        busy_d = (state_d == ST_SHIFT);
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Overrun flag: a word landed on top of an unacknowledged one
    always_comb begin
        if (word_done_s && rx_valid_q && !rx_ack) begin
            overrun_d = 1'b1;
        end else if (rx_ack) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Overrun flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign rx_overrun = overrun_q;
`endif

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave (DATA_WIDTH=8, SPI mode 0).
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rx_overrun;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    spi_slave #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_overrun (rx_overrun),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master shifts nbits of mo (MSB first), sampling miso just before each rise.
    // chg_tx swaps tx_data after the 4th bit; ack_last pulses rx_ack in the completion cycle.
    task automatic xfer(input logic [7:0] mo, input int nbits, input logic chg_tx,
                        input logic [7:0] tx_next, input logic ack_last, output logic [7:0] mi);
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            mosi = mo[7-k];
            wait_clks(6);
            mi[7-k] = miso;
            sclk = 1'b1;
            if (ack_last && k == nbits - 1) begin
                wait_clks(2);
                rx_ack = 1'b1;
                wait_clks(1);
                rx_ack = 1'b0;
                wait_clks(3);
            end else begin
                wait_clks(6);
            end
            sclk = 1'b0;
            if (chg_tx && k == 3) tx_data = tx_next;
        end
        wait_clks(6);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        wait_clks(1);
        rx_ack = 1'b0;
        wait_clks(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = 8'h00; rx_ack = 1'b0;
        wait_clks(3);
        total_cnt++; if (miso !== 1'b0) $display("FAIL rst_miso: got %b expected 0", miso); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL rst_rx_data: got %h expected 00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
        rst_n = 1'b1;
        wait_clks(5);
        total_cnt++; if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (miso !== 1'b0) $display("FAIL post_rst_miso: got %b expected 0", miso); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [7:0] mi;
        tx_data = 8'h3C;
        cs_n = 1'b0;
        wait_clks(5);
        total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy); else pass_cnt++;
        xfer(8'hA5, 8, 1'b0, 8'h00, 1'b0, mi);
        total_cnt++; if (mi !== 8'h3C) $display("FAIL basic_miso_bits: got %h expected 3c", mi); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'hA5) $display("FAIL basic_rx_data: got %h expected a5", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL basic_rx_valid: got %b expected 1", rx_valid); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL basic_ack: got %b expected 0", rx_valid); else pass_cnt++;
        cs_n = 1'b1;
        wait_clks(6);
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (miso !== 1'b0) $display("FAIL basic_idle_miso: got %b expected 0", miso); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi;
        tx_data = 8'hC9;
        cs_n = 1'b0;
        wait_clks(2);
        xfer(8'h12, 8, 1'b1, 8'h6B, 1'b0, mi);
        total_cnt++; if (mi !== 8'hC9) $display("FAIL b2b_miso_w1: got %h expected c9", mi); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h12) $display("FAIL b2b_rx_w1: got %h expected 12", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid_w1: got %b expected 1", rx_valid); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL b2b_ack_w1: got %b expected 0", rx_valid); else pass_cnt++;
        xfer(8'h34, 8, 1'b0, 8'h00, 1'b0, mi);
        total_cnt++; if (mi !== 8'h6B) $display("FAIL b2b_miso_w2: got %h expected 6b", mi); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h34) $display("FAIL b2b_rx_w2: got %h expected 34", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid_w2: got %b expected 1", rx_valid); else pass_cnt++;
        pulse_ack();
        cs_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_partial_and_idle();
        logic [7:0] mi;
        tx_data = 8'hFF;
        cs_n = 1'b0;
        wait_clks(2);
        xfer(8'hFF, 5, 1'b0, 8'h00, 1'b0, mi);
        cs_n = 1'b1;
        wait_clks(6);
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL partial_valid: got %b expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h34) $display("FAIL partial_rx_data: got %h expected 34", rx_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL partial_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (miso !== 1'b0) $display("FAIL partial_miso: got %b expected 0", miso); else pass_cnt++;
        // sclk toggling with cs_n high must not advance the bit counter
        xfer(8'hFF, 3, 1'b0, 8'h00, 1'b0, mi);
        total_cnt++; if (miso !== 1'b0) $display("FAIL idle_sclk_miso: got %b expected 0", miso); else pass_cnt++;
        cs_n = 1'b0;
        wait_clks(2);
        xfer(8'h69, 8, 1'b0, 8'h00, 1'b0, mi);
        total_cnt++; if (rx_data !== 8'h69) $display("FAIL idle_sclk_rx: got %h expected 69", rx_data); else pass_cnt++;
        pulse_ack();
        cs_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_reset_abort();
        logic [7:0] mi;
        cs_n = 1'b0;
        wait_clks(2);
        xfer(8'hF0, 4, 1'b0, 8'h00, 1'b0, mi);
        rst_n = 1'b0;
        cs_n = 1'b1;
        wait_clks(2);
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL abort_rst_rx: got %h expected 00", rx_data); else pass_cnt++;
        rst_n = 1'b1;
        wait_clks(4);
        cs_n = 1'b0;
        wait_clks(2);
        xfer(8'hC3, 8, 1'b0, 8'h00, 1'b0, mi);
        total_cnt++; if (rx_data !== 8'hC3) $display("FAIL abort_rx_data: got %h expected c3", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL abort_rx_valid: got %b expected 1", rx_valid); else pass_cnt++;
        cs_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_ack_same_cycle();
        logic [7:0] mi;
        cs_n = 1'b0;
        wait_clks(2);
        xfer(8'h5E, 8, 1'b0, 8'h00, 1'b1, mi);
        total_cnt++; if (rx_data !== 8'h5E) $display("FAIL ackcoll_rx_data: got %h expected 5e", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL ackcoll_valid: got %b expected 1", rx_valid); else pass_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
        total_cnt++; if (rx_overrun !== 1'b0) $display("FAIL ackcoll_overrun: got %b expected 0", rx_overrun); else pass_cnt++;
`endif
        pulse_ack();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL ackcoll_clear: got %b expected 0", rx_valid); else pass_cnt++;
        cs_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_overwrite();
        logic [7:0] mi;
        cs_n = 1'b0;
        wait_clks(2);
        xfer(8'hA1, 8, 1'b0, 8'h00, 1'b0, mi);
        xfer(8'h7E, 8, 1'b0, 8'h00, 1'b0, mi);
        total_cnt++; if (rx_data !== 8'h7E) $display("FAIL ovr_rx_data: got %h expected 7e", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", rx_valid); else pass_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
        total_cnt++; if (rx_overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", rx_overrun); else pass_cnt++;
`endif
        pulse_ack();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b expected 0", rx_valid); else pass_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
        total_cnt++; if (rx_overrun !== 1'b0) $display("FAIL ovr_ack_flag: got %b expected 0", rx_overrun); else pass_cnt++;
`endif
        cs_n = 1'b1;
        wait_clks(6);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_partial_and_idle();
        test_reset_abort();
        test_ack_same_cycle();
        test_overwrite();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
